// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Byte-serial valid/ready program loader that fills instruction
//               memory from address 0 and holds the core until the image is in.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              mem_wEn,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_run,
    output logic              load_err,
    output logic [ADDR_W-1:0] byte_count,
    output logic [7:0]        checksum
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;
    localparam logic [1:0] c_ERR  = 2'd3;

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(MEM_BYTES - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_stateNext;
    logic              w_accept;
    logic              w_start;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_sum;
    logic              r_wEn;
    logic [ADDR_W-1:0] r_memAddr;
    logic [7:0]        r_memData;

    // load_req is only honoured outside LOAD; a load in progress cannot be restarted
    always_comb begin
        w_accept    = (r_state == c_LOAD) && s_valid;
        w_start     = load_req && (r_state != c_LOAD);
        w_stateNext = r_state;
        case (r_state)
            c_IDLE, c_DONE, c_ERR: begin
                if (load_req) begin
                    w_stateNext = c_LOAD;
                end
            end
            c_LOAD: begin
                if (w_accept) begin
                    if (s_last) begin
                        w_stateNext = c_DONE;
                    end else if (r_addr == c_LAST_ADDR) begin
                        w_stateNext = c_ERR;
                    end
                end
            end
            default: w_stateNext = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // The address counter doubles as the byte count: both start at 0 and step per accepted byte
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr    <= '0;
            r_sum     <= '0;
            r_wEn     <= 1'b0;
            r_memAddr <= '0;
            r_memData <= '0;
        end else begin
            r_wEn <= w_accept;
            if (w_start) begin
                r_addr <= '0;
                r_sum  <= '0;
            end else if (w_accept) begin
                r_addr    <= r_addr + ADDR_W'(1);
                r_sum     <= r_sum + s_data;
                r_memAddr <= r_addr;
                r_memData <= s_data;
            end
        end
    end

    assign s_ready    = (r_state == c_LOAD);
    assign cpu_run    = (r_state == c_DONE);
    assign load_err   = (r_state == c_ERR);
    assign mem_wEn    = r_wEn;
    assign mem_addr   = r_memAddr;
    assign mem_wdata  = r_memData;
    assign byte_count = r_addr;
    assign checksum   = r_sum;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader (vector table + write scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int c_MEM = 8;
    localparam int c_AW  = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            load_req;
    logic            s_valid;
    logic [7:0]      s_data;
    logic            s_last;
    logic            s_ready;
    logic            mem_wEn;
    logic [c_AW-1:0] mem_addr;
    logic [7:0]      mem_wdata;
    logic            cpu_run;
    logic            load_err;
    logic [c_AW-1:0] byte_count;
    logic [7:0]      checksum;

    imem_loader #(.MEM_BYTES(c_MEM), .ADDR_W(c_AW)) dut (
        .clk(clk), .rst(rst), .load_req(load_req),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .mem_wEn(mem_wEn), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_run(cpu_run), .load_err(load_err),
        .byte_count(byte_count), .checksum(checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            req;
        logic            valid;
        logic [7:0]      data;
        logic            last;
        logic            ready;
        logic            run;
        logic            err;
        logic [c_AW-1:0] count;
        logic [7:0]      sum;
    } row_t;

    typedef struct {
        logic [c_AW-1:0] addr;
        logic [7:0]      data;
    } wr_t;

    row_t            rows[$];
    wr_t             sb[$];
    int              nChecks = 0;
    int              nPass   = 0;
    logic            expReady = 1'b0;
    logic [c_AW-1:0] expAddr  = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void addRow(input logic req, input logic v, input logic [7:0] d,
                                   input logic l, input logic rdy, input logic run,
                                   input logic err, input int cnt, input logic [7:0] sum);
        row_t r;
        r.req = req; r.valid = v; r.data = d; r.last = l;
        r.ready = rdy; r.run = run; r.err = err; r.count = c_AW'(cnt); r.sum = sum;
        rows.push_back(r);
    endfunction

    // Drive one cycle of stimulus, predict any write, then check the post-edge state
    task automatic applyRow(input row_t r, input int idx);
        wr_t w;
        @(negedge clk);
        load_req = r.req; s_valid = r.valid; s_data = r.data; s_last = r.last;
        if (r.req && !expReady) expAddr = '0;
        if (r.valid && expReady) begin
            w.addr = expAddr; w.data = r.data;
            sb.push_back(w);
            expAddr = expAddr + 1;
        end
        @(posedge clk); #1;
        chk($sformatf("row%0d_ready", idx), 64'(s_ready), 64'(r.ready));
        chk($sformatf("row%0d_run", idx), 64'(cpu_run), 64'(r.run));
        chk($sformatf("row%0d_err", idx), 64'(load_err), 64'(r.err));
        chk($sformatf("row%0d_count", idx), byte_count, r.count);
        chk($sformatf("row%0d_sum", idx), 64'(checksum), 64'(r.sum));
        expReady = r.ready;
    endtask

    // Write monitor: every strobe must match the oldest predicted write
    always @(posedge clk) begin
        #1;
        if (mem_wEn) begin
            if (sb.size() == 0) begin
                chk("wr_unexpected", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", mem_addr, e.addr);
                chk("wr_data", 64'(mem_wdata), 64'(e.data));
            end
        end
    end

    initial begin
        logic [7:0] d;
        logic [7:0] s;
        row_t       r;

        rst = 1'b0; load_req = 1'b0; s_valid = 1'b1; s_data = 8'hA5; s_last = 1'b0;

        // Image 30 F2 0A 00, then a stray byte once loaded
        addRow(1, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00);
        addRow(0, 1, 8'h30, 0, 1, 0, 0, 1, 8'h30);
        addRow(0, 1, 8'hF2, 0, 1, 0, 0, 2, 8'h22);
        addRow(0, 1, 8'h0A, 0, 1, 0, 0, 3, 8'h2C);
        addRow(0, 1, 8'h00, 1, 0, 1, 0, 4, 8'h2C);
        addRow(0, 1, 8'h55, 0, 0, 1, 0, 4, 8'h2C);
        // Restart from DONE; same image with gaps and an ignored load_req mid-load
        addRow(1, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00);
        addRow(0, 1, 8'h30, 0, 1, 0, 0, 1, 8'h30);
        addRow(1, 0, 8'h77, 0, 1, 0, 0, 1, 8'h30);
        addRow(0, 1, 8'hF2, 0, 1, 0, 0, 2, 8'h22);
        addRow(0, 0, 8'h66, 0, 1, 0, 0, 2, 8'h22);
        addRow(0, 1, 8'h0A, 0, 1, 0, 0, 3, 8'h2C);
        addRow(0, 0, 8'h11, 1, 1, 0, 0, 3, 8'h2C);
        addRow(0, 1, 8'h00, 1, 0, 1, 0, 4, 8'h2C);
        addRow(0, 0, 8'h00, 0, 0, 1, 0, 4, 8'h2C);
        // Overflow: 9 bytes, no s_last
        addRow(1, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00);
        s = 8'h00;
        for (int i = 0; i < 8; i++) begin
            d = 8'(i * 17 + 1);
            s = s + d;
            addRow(0, 1, d, 0, i < 7, 0, i == 7, i + 1, s);
        end
        addRow(0, 1, 8'h99, 0, 0, 0, 1, 8, s);
        // Exactly-full image with s_last on the final address
        addRow(1, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00);
        s = 8'h00;
        for (int i = 0; i < 8; i++) begin
            d = 8'(8'hF0 + i);
            s = s + d;
            addRow(0, 1, d, i == 7, i < 7, i == 7, 0, i + 1, s);
        end
        // Restart from DONE with a 2-byte image
        addRow(1, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00);
        addRow(0, 1, 8'hAB, 0, 1, 0, 0, 1, 8'hAB);
        addRow(0, 1, 8'hCD, 1, 0, 1, 0, 2, 8'h78);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(s_ready), 64'(0));
        chk("rst_wen", 64'(mem_wEn), 64'(0));
        chk("rst_addr", mem_addr, 64'(0));
        chk("rst_wdata", 64'(mem_wdata), 64'(0));
        chk("rst_run", 64'(cpu_run), 64'(0));
        chk("rst_err", 64'(load_err), 64'(0));
        chk("rst_count", byte_count, 64'(0));
        chk("rst_sum", 64'(checksum), 64'(0));
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b0;

        foreach (rows[i]) applyRow(rows[i], i);

        @(negedge clk);
        load_req = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        @(posedge clk); #1;
        chk("hold_wen", 64'(mem_wEn), 64'(0));
        chk("hold_addr", mem_addr, 64'(1));
        chk("hold_wdata", 64'(mem_wdata), 64'(8'hCD));

        // Reset after 3 of 6 bytes, then a clean reload
        r = '{req: 1'b1, valid: 1'b0, data: 8'h00, last: 1'b0, ready: 1'b1,
              run: 1'b0, err: 1'b0, count: '0, sum: 8'h00};
        applyRow(r, 100);
        s = 8'h00;
        for (int i = 0; i < 3; i++) begin
            d = 8'(8'h10 * (i + 1));
            s = s + d;
            r = '{req: 1'b0, valid: 1'b1, data: d, last: 1'b0, ready: 1'b1,
                  run: 1'b0, err: 1'b0, count: c_AW'(i + 1), sum: s};
            applyRow(r, 101 + i);
        end
        @(negedge clk);
        rst = 1'b0; s_valid = 1'b1; s_data = 8'h40;
        @(posedge clk); #1;
        chk("mid_rst_ready", 64'(s_ready), 64'(0));
        chk("mid_rst_wen", 64'(mem_wEn), 64'(0));
        chk("mid_rst_addr", mem_addr, 64'(0));
        chk("mid_rst_wdata", 64'(mem_wdata), 64'(0));
        chk("mid_rst_run", 64'(cpu_run), 64'(0));
        chk("mid_rst_err", 64'(load_err), 64'(0));
        chk("mid_rst_count", byte_count, 64'(0));
        chk("mid_rst_sum", 64'(checksum), 64'(0));
        expReady = 1'b0;
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b0;

        r = '{req: 1'b1, valid: 1'b0, data: 8'h00, last: 1'b0, ready: 1'b1,
              run: 1'b0, err: 1'b0, count: '0, sum: 8'h00};
        applyRow(r, 200);
        s = 8'h00;
        for (int i = 0; i < 6; i++) begin
            d = 8'(8'h10 * (i + 1));
            s = s + d;
            r = '{req: 1'b0, valid: 1'b1, data: d, last: (i == 5), ready: (i < 5),
                  run: (i == 5), err: 1'b0, count: c_AW'(i + 1), sum: s};
            applyRow(r, 201 + i);
        end
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("sb_drain", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
